wb_pcie_tx_arb: RTL and testbench



---
 rtl/wb_pcie_tx_arb.sv | 186 ++++++++++++++++++
 tb/tb_wb_pcie_tx_arb.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pcie_tx_arb.sv
// Two-source packet-granular round-robin arbiter in front of the PCIe HIP 64-bit Avalon-ST TX port.
// Optional per-source packet counters are built when WB_PCIE_TX_ARB_STATS_EN is defined.
module wb_pcie_tx_arb #(
   parameter int READY_LATENCY = 2
) (
   input  logic        pld_clk,
   input  logic        npor,
   input  logic        link_up,
   input  logic        src0_valid,
   input  logic        src0_sop,
   input  logic        src0_eop,
   input  logic [63:0] src0_data,
   output logic        src0_ready,
   input  logic        src1_valid,
   input  logic        src1_sop,
   input  logic        src1_eop,
   input  logic [63:0] src1_data,
   output logic        src1_ready,
   input  logic        tx_st_ready,
   output logic        tx_st_valid,
   output logic        tx_st_sop,
   output logic        tx_st_eop,
   output logic [63:0] tx_st_data,
   output logic        tx_st_err,
   output logic [1:0]  grant,
   output logic        proto_err
`ifdef WB_PCIE_TX_ARB_STATS_EN
   ,
   output logic [15:0] pkt_cnt0,
   output logic [15:0] pkt_cnt1
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PKT0 = 2'd1;
   localparam logic [1:0] PKT1 = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        last_q, last_d;
   logic        first_q, first_d;
   logic        err_q, err_d;
   logic        tx_valid_q, tx_sop_q, tx_eop_q;
   logic [63:0] tx_data_q;

   logic        allow;
   logic        sel0, sel1;
   logic        cand0, cand1;
   logic        beat_valid, beat_sop, beat_eop;
   logic [63:0] beat_data;
   logic        accept;

   // allow is tx_st_ready aligned so that a beat accepted now meets the HIP ready latency
   generate
      if (READY_LATENCY <= 1) begin : g_rl_one
         assign allow = tx_st_ready;
      end else begin : g_rl_pipe
         logic [READY_LATENCY-2:0] rdy_pipe_q;
         always_ff @(posedge pld_clk or negedge npor) begin
            if (!npor) begin
               rdy_pipe_q <= '0;
            end else begin
               rdy_pipe_q[0] <= tx_st_ready;
               for (int i = 1; i < READY_LATENCY - 1; i++) begin
                  rdy_pipe_q[i] <= rdy_pipe_q[i-1];
               end
            end
         end
         assign allow = rdy_pipe_q[READY_LATENCY-2];
      end
   endgenerate

   assign sel0  = (state_q == PKT0);
   assign sel1  = (state_q == PKT1);
   assign cand0 = src0_valid & src0_sop & link_up;
   assign cand1 = src1_valid & src1_sop & link_up;

   assign src0_ready = sel0 & allow;
   assign src1_ready = sel1 & allow;

   assign beat_valid = (sel0 & src0_valid) | (sel1 & src1_valid);
   assign beat_sop   = sel1 ? src1_sop  : src0_sop;
   assign beat_eop   = sel1 ? src1_eop  : src0_eop;
   assign beat_data  = sel1 ? src1_data : src0_data;
   assign accept     = (sel0 | sel1) & allow & beat_valid;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      first_d = first_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            first_d = 1'b1;
            if ((src0_valid & ~src0_sop) | (src1_valid & ~src1_sop)) begin
               err_d = 1'b1;
            end
            if (cand0 & cand1) begin
               state_d = last_q ? PKT0 : PKT1;
               last_d  = ~last_q;
            end else if (cand0) begin
               state_d = PKT0;
               last_d  = 1'b0;
            end else if (cand1) begin
               state_d = PKT1;
               last_d  = 1'b1;
            end
         end
         PKT0, PKT1: begin
            if (allow & ~beat_valid) begin
               err_d = 1'b1;
            end
            if (accept) begin
               first_d = 1'b0;
               if (beat_sop & ~first_q) begin
                  err_d = 1'b1;
               end
               if (beat_eop) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pld_clk or negedge npor) begin
      if (!npor) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         first_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         first_q <= first_d;
         err_q   <= err_d;
      end
   end

   // Output beat register; sop/eop are forced low on bubble cycles
   always_ff @(posedge pld_clk or negedge npor) begin
      if (!npor) begin
         tx_valid_q <= 1'b0;
         tx_sop_q   <= 1'b0;
         tx_eop_q   <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         tx_valid_q <= accept;
         tx_sop_q   <= accept & beat_sop;
         tx_eop_q   <= accept & beat_eop;
         if (accept) begin
            tx_data_q <= beat_data;
         end
      end
   end

   assign tx_st_valid = tx_valid_q;
   assign tx_st_sop   = tx_sop_q;
   assign tx_st_eop   = tx_eop_q;
   assign tx_st_data  = tx_data_q;
   assign tx_st_err   = 1'b0;
   assign grant       = {sel1, sel0};
   assign proto_err   = err_q;

`ifdef WB_PCIE_TX_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt1_q;

   always_ff @(posedge pld_clk or negedge npor) begin
      if (!npor) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (accept & beat_eop & sel0) begin
            cnt0_q <= cnt0_q + 16'd1;
         end
         if (accept & beat_eop & sel1) begin
            cnt1_q <= cnt1_q + 16'd1;
         end
      end
   end

   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_wb_pcie_tx_arb.sv
// Directed bench for wb_pcie_tx_arb: table of per-cycle vectors plus hand-written
// sequences for ready stalls and asynchronous reset in mid-packet.
module tb_wb_pcie_tx_arb;

   localparam int RL = 2;

   logic        pld_clk;
   logic        npor;
   logic        link_up;
   logic        src0_valid, src0_sop, src0_eop;
   logic [63:0] src0_data;
   logic        src0_ready;
   logic        src1_valid, src1_sop, src1_eop;
   logic [63:0] src1_data;
   logic        src1_ready;
   logic        tx_st_ready;
   logic        tx_st_valid, tx_st_sop, tx_st_eop;
   logic [63:0] tx_st_data;
   logic        tx_st_err;
   logic [1:0]  grant;
   logic        proto_err;
`ifdef WB_PCIE_TX_ARB_STATS_EN
   logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

   int nCompared   = 0;
   int nMismatched = 0;

   wb_pcie_tx_arb #(.READY_LATENCY(RL)) dut (
      .pld_clk     (pld_clk),
      .npor        (npor),
      .link_up     (link_up),
      .src0_valid  (src0_valid),
      .src0_sop    (src0_sop),
      .src0_eop    (src0_eop),
      .src0_data   (src0_data),
      .src0_ready  (src0_ready),
      .src1_valid  (src1_valid),
      .src1_sop    (src1_sop),
      .src1_eop    (src1_eop),
      .src1_data   (src1_data),
      .src1_ready  (src1_ready),
      .tx_st_ready (tx_st_ready),
      .tx_st_valid (tx_st_valid),
      .tx_st_sop   (tx_st_sop),
      .tx_st_eop   (tx_st_eop),
      .tx_st_data  (tx_st_data),
      .tx_st_err   (tx_st_err),
      .grant       (grant),
      .proto_err   (proto_err)
`ifdef WB_PCIE_TX_ARB_STATS_EN
      ,
      .pkt_cnt0    (pkt_cnt0),
      .pkt_cnt1    (pkt_cnt1)
`endif
   );

   initial pld_clk = 1'b0;
   always #5 pld_clk = ~pld_clk;

   // Source fields are {valid, sop, eop}
   typedef struct {
      bit          doRst;
      bit          lu;
      bit          txr;
      logic [2:0]  s0;
      logic [63:0] d0;
      logic [2:0]  s1;
      logic [63:0] d1;
      logic [1:0]  eGrant;
      bit          eR0;
      bit          eR1;
      bit          eTv;
      bit          eSop;
      bit          eEop;
      logic [63:0] eData;
      bit          ePerr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit doRst, bit lu, bit txr, logic [2:0] s0, logic [63:0] d0,
                               logic [2:0] s1, logic [63:0] d1, logic [1:0] g, bit r0, bit r1,
                               bit tv, bit ts, bit te, logic [63:0] td, bit pe);
      vec_t v;
      v.doRst = doRst; v.lu = lu; v.txr = txr;
      v.s0 = s0; v.d0 = d0; v.s1 = s1; v.d1 = d1;
      v.eGrant = g; v.eR0 = r0; v.eR1 = r1;
      v.eTv = tv; v.eSop = ts; v.eEop = te; v.eData = td; v.ePerr = pe;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic clearInputs();
      src0_valid = 1'b0; src0_sop = 1'b0; src0_eop = 1'b0; src0_data = '0;
      src1_valid = 1'b0; src1_sop = 1'b0; src1_eop = 1'b0; src1_data = '0;
   endtask

   // Leaves the DUT in IDLE with the ready pipeline filled, at posedge+1
   task automatic resetDut();
      clearInputs();
      tx_st_ready = 1'b1;
      link_up     = 1'b1;
      npor        = 1'b0;
      @(posedge pld_clk);
      @(posedge pld_clk);
      @(negedge pld_clk);
      npor = 1'b1;
      @(posedge pld_clk);
      @(posedge pld_clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      link_up     = v.lu;
      tx_st_ready = v.txr;
      {src0_valid, src0_sop, src0_eop} = v.s0;
      src0_data   = v.d0;
      {src1_valid, src1_sop, src1_eop} = v.s1;
      src1_data   = v.d1;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      chk($sformatf("v%0d.grant", idx), {62'd0, grant}, {62'd0, v.eGrant});
      chk($sformatf("v%0d.src0_ready", idx), {63'd0, src0_ready}, {63'd0, v.eR0});
      chk($sformatf("v%0d.src1_ready", idx), {63'd0, src1_ready}, {63'd0, v.eR1});
      chk($sformatf("v%0d.tx_valid", idx), {63'd0, tx_st_valid}, {63'd0, v.eTv});
      if (v.eTv) begin
         chk($sformatf("v%0d.tx_sop", idx), {63'd0, tx_st_sop}, {63'd0, v.eSop});
         chk($sformatf("v%0d.tx_eop", idx), {63'd0, tx_st_eop}, {63'd0, v.eEop});
         chk($sformatf("v%0d.tx_data", idx), tx_st_data, v.eData);
      end
      chk($sformatf("v%0d.proto_err", idx), {63'd0, proto_err}, {63'd0, v.ePerr});
      chk($sformatf("v%0d.tx_err", idx), {63'd0, tx_st_err}, 64'd0);
   endtask

   task automatic checkAllZero(input string tag);
      chk({tag, ".grant"}, {62'd0, grant}, 64'd0);
      chk({tag, ".src0_ready"}, {63'd0, src0_ready}, 64'd0);
      chk({tag, ".src1_ready"}, {63'd0, src1_ready}, 64'd0);
      chk({tag, ".tx_valid"}, {63'd0, tx_st_valid}, 64'd0);
      chk({tag, ".tx_sop"}, {63'd0, tx_st_sop}, 64'd0);
      chk({tag, ".tx_eop"}, {63'd0, tx_st_eop}, 64'd0);
      chk({tag, ".tx_data"}, tx_st_data, 64'd0);
      chk({tag, ".proto_err"}, {63'd0, proto_err}, 64'd0);
`ifdef WB_PCIE_TX_ARB_STATS_EN
      chk({tag, ".pkt_cnt0"}, {48'd0, pkt_cnt0}, 64'd0);
      chk({tag, ".pkt_cnt1"}, {48'd0, pkt_cnt1}, 64'd0);
`endif
   endtask

   // An 8-beat src0 packet with tx_st_ready low during cycles 4..6
   task automatic runStallTest();
      int          idx;
      bit          accepted;
      bit          txrHist[16];
      bit          expTv;
      logic [63:0] gotData[$];
      bit          gotSop[$];
      bit          gotEop[$];
      resetDut();
      idx = 0;
      for (int c = 0; c < 16; c++) begin
         src0_valid  = (idx < 8);
         src0_sop    = (idx == 0);
         src0_eop    = (idx == 7);
         src0_data   = 64'h3000 + 64'(idx);
         tx_st_ready = !(c >= 4 && c <= 6);
         txrHist[c]  = tx_st_ready;
         @(negedge pld_clk);
         accepted = src0_valid & src0_ready;
         expTv    = (c >= 2 && c <= 12 && !(c >= 6 && c <= 8));
         chk($sformatf("stall.c%0d.tx_valid", c), {63'd0, tx_st_valid}, {63'd0, expTv});
         if (tx_st_valid) begin
            gotData.push_back(tx_st_data);
            gotSop.push_back(tx_st_sop);
            gotEop.push_back(tx_st_eop);
            if (c >= RL) begin
               chk($sformatf("stall.c%0d.hip_rule", c), {63'd0, txrHist[c-RL]}, 64'd1);
            end
         end
         @(posedge pld_clk);
         #1;
         if (accepted) idx++;
      end
      tx_st_ready = 1'b1;
      chk("stall.beats_accepted", 64'(idx), 64'd8);
      chk("stall.beats_out", 64'(gotData.size()), 64'd8);
      for (int i = 0; i < gotData.size(); i++) begin
         chk($sformatf("stall.beat%0d.data", i), gotData[i], 64'h3000 + 64'(i));
         chk($sformatf("stall.beat%0d.sop", i), {63'd0, gotSop[i]}, {63'd0, (i == 0)});
         chk($sformatf("stall.beat%0d.eop", i), {63'd0, gotEop[i]}, {63'd0, (i == 7)});
      end
      chk("stall.proto_err", {63'd0, proto_err}, 64'd0);
`ifdef WB_PCIE_TX_ARB_STATS_EN
      chk("stall.pkt_cnt0", {48'd0, pkt_cnt0}, 64'd1);
`endif
   endtask

   // npor asserted while the second beat is on tx_st, then a fresh packet
   task automatic runResetMidPacket();
      resetDut();
      src0_valid = 1'b1; src0_sop = 1'b1; src0_eop = 1'b0; src0_data = 64'h60;
      @(negedge pld_clk);
      chk("rstmid.c0.grant", {62'd0, grant}, 64'd0);
      @(posedge pld_clk); #1;
      @(negedge pld_clk);
      chk("rstmid.c1.grant", {62'd0, grant}, 64'd1);
      @(posedge pld_clk); #1;
      src0_sop = 1'b0; src0_data = 64'h61;
      @(negedge pld_clk);
      chk("rstmid.c2.tx_data", tx_st_data, 64'h60);
      @(posedge pld_clk); #1;
      src0_data = 64'h62;
      @(negedge pld_clk);
      chk("rstmid.c3.tx_valid", {63'd0, tx_st_valid}, 64'd1);
      chk("rstmid.c3.tx_data", tx_st_data, 64'h61);
      #2;
      npor = 1'b0;
      #1;
      checkAllZero("rstmid.async");
      clearInputs();
      @(posedge pld_clk);
      @(posedge pld_clk);
      @(negedge pld_clk);
      npor = 1'b1;
      @(posedge pld_clk);
      @(posedge pld_clk);
      #1;
      src0_valid = 1'b1; src0_sop = 1'b1; src0_eop = 1'b1; src0_data = 64'h70;
      @(negedge pld_clk);
      chk("rstmid.f0.grant", {62'd0, grant}, 64'd0);
      chk("rstmid.f0.src0_ready", {63'd0, src0_ready}, 64'd0);
      @(posedge pld_clk); #1;
      @(negedge pld_clk);
      chk("rstmid.f1.grant", {62'd0, grant}, 64'd1);
      chk("rstmid.f1.src0_ready", {63'd0, src0_ready}, 64'd1);
      @(posedge pld_clk); #1;
      clearInputs();
      @(negedge pld_clk);
      chk("rstmid.f2.tx_valid", {63'd0, tx_st_valid}, 64'd1);
      chk("rstmid.f2.tx_data", tx_st_data, 64'h70);
      chk("rstmid.f2.tx_sop_eop", {62'd0, tx_st_sop, tx_st_eop}, 64'd3);
      chk("rstmid.f2.grant", {62'd0, grant}, 64'd0);
      chk("rstmid.f2.proto_err", {63'd0, proto_err}, 64'd0);
`ifdef WB_PCIE_TX_ARB_STATS_EN
      chk("rstmid.f2.pkt_cnt0", {48'd0, pkt_cnt0}, 64'd1);
`endif
      @(posedge pld_clk); #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clearInputs();
      tx_st_ready = 1'b1;
      link_up     = 1'b1;
      npor        = 1'b0;
      @(negedge pld_clk);
      checkAllZero("reset");

      // 4-beat src0 packet
      vecs.push_back(mk(1,1,1,3'b110,64'hA0,3'b000,64'h0,2'b00,0,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b110,64'hA0,3'b000,64'h0,2'b01,1,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b100,64'hA1,3'b000,64'h0,2'b01,1,0,1,1,0,64'hA0,0));
      vecs.push_back(mk(0,1,1,3'b100,64'hA2,3'b000,64'h0,2'b01,1,0,1,0,0,64'hA1,0));
      vecs.push_back(mk(0,1,1,3'b101,64'hA3,3'b000,64'h0,2'b01,1,0,1,0,0,64'hA2,0));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b00,0,0,1,0,1,64'hA3,0));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b00,0,0,0,0,0,64'h0,0));
      // Both sources contend with single-beat packets: 0,1,0,1
      vecs.push_back(mk(1,1,1,3'b111,64'hB000,3'b111,64'hC000,2'b00,0,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b111,64'hB000,3'b111,64'hC000,2'b01,1,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b111,64'hB001,3'b111,64'hC000,2'b00,0,0,1,1,1,64'hB000,0));
      vecs.push_back(mk(0,1,1,3'b111,64'hB001,3'b111,64'hC000,2'b10,0,1,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b111,64'hB001,3'b111,64'hC001,2'b00,0,0,1,1,1,64'hC000,0));
      vecs.push_back(mk(0,1,1,3'b111,64'hB001,3'b111,64'hC001,2'b01,1,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b111,64'hB002,3'b111,64'hC001,2'b00,0,0,1,1,1,64'hB001,0));
      vecs.push_back(mk(0,1,1,3'b111,64'hB002,3'b111,64'hC001,2'b10,0,1,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b00,0,0,1,1,1,64'hC001,0));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b00,0,0,0,0,0,64'h0,0));
      // link_up low holds off a pending src1 packet; rises at cycle 4
      vecs.push_back(mk(1,0,1,3'b000,64'h0,3'b111,64'hE0,2'b00,0,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,0,1,3'b000,64'h0,3'b111,64'hE0,2'b00,0,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,0,1,3'b000,64'h0,3'b111,64'hE0,2'b00,0,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,0,1,3'b000,64'h0,3'b111,64'hE0,2'b00,0,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b111,64'hE0,2'b00,0,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b111,64'hE0,2'b10,0,1,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b00,0,0,1,1,1,64'hE0,0));
      // Granted src0 drops valid for one allow cycle
      vecs.push_back(mk(1,1,1,3'b110,64'hD0,3'b000,64'h0,2'b00,0,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b110,64'hD0,3'b000,64'h0,2'b01,1,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b01,1,0,1,1,0,64'hD0,0));
      vecs.push_back(mk(0,1,1,3'b100,64'hD1,3'b000,64'h0,2'b01,1,0,0,0,0,64'h0,1));
      vecs.push_back(mk(0,1,1,3'b101,64'hD2,3'b000,64'h0,2'b01,1,0,1,0,0,64'hD1,1));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b00,0,0,1,0,1,64'hD2,1));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b00,0,0,0,0,0,64'h0,1));
      // src1 valid without sop while idle
      vecs.push_back(mk(1,1,1,3'b000,64'h0,3'b100,64'h55,2'b00,0,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b00,0,0,0,0,0,64'h0,1));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b00,0,0,0,0,0,64'h0,1));
      // Second sop accepted inside a packet
      vecs.push_back(mk(1,1,1,3'b110,64'hF0,3'b000,64'h0,2'b00,0,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b110,64'hF0,3'b000,64'h0,2'b01,1,0,0,0,0,64'h0,0));
      vecs.push_back(mk(0,1,1,3'b111,64'hF1,3'b000,64'h0,2'b01,1,0,1,1,0,64'hF0,0));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b00,0,0,1,1,1,64'hF1,1));
      vecs.push_back(mk(0,1,1,3'b000,64'h0,3'b000,64'h0,2'b00,0,0,0,0,0,64'h0,1));

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].doRst) resetDut();
         applyStimulus(vecs[i]);
         @(negedge pld_clk);
         checkOutput(vecs[i], i);
         @(posedge pld_clk);
         #1;
      end

      runStallTest();
      runResetMidPacket();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
